mem_ctrl_arbiter: RTL

MEM_CTRL_ARBITER -- requirements
Module: mem_ctrl_arbiter

---
 rtl/mem_ctrl_arbiter.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/mem_ctrl_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_ctrl_arbiter
// Purpose  : Two-requester (icache/dcache) arbiter in front of main memory,
//            one outstanding transaction, icache priority with dcache
//            starvation guard.
// Revision : 1.0 - initial release
// ============================================================================

typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
} req_type_t;

typedef logic [31:0] main_mem_block_addr_t;
typedef logic [63:0] block_data_t;

module mem_ctrl_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic                 clk,
    input  logic                 rst_aL,

    input  logic                 ic_req_valid,
    input  req_type_t            ic_req_type,
    input  main_mem_block_addr_t ic_req_block_addr,
    input  block_data_t          ic_req_block_data,
    output logic                 ic_req_ready,
    output logic                 ic_resp_valid,
    output block_data_t          ic_resp_block_data,

    input  logic                 dc_req_valid,
    input  req_type_t            dc_req_type,
    input  main_mem_block_addr_t dc_req_block_addr,
    input  block_data_t          dc_req_block_data,
    output logic                 dc_req_ready,
    output logic                 dc_resp_valid,
    output block_data_t          dc_resp_block_data,

    output logic                 mem_req_valid,
    output req_type_t            mem_req_type,
    output main_mem_block_addr_t mem_req_block_addr,
    output block_data_t          mem_req_block_data,
    input  logic                 mem_req_ready,
    input  logic                 mem_resp_valid,
    input  block_data_t          mem_resp_block_data,

    output logic                 busy,
    output logic                 owner
);

    localparam int STREAK_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [STREAK_W-1:0]  streak;
    req_type_t            lat_type;
    main_mem_block_addr_t lat_addr;
    block_data_t          lat_data;
    logic                 lat_owner;
    logic                 grant_ic;
    logic                 grant_dc;

    // dcache wins only when icache is silent or has used up its streak
    always_comb begin
        grant_ic = 1'b0;
        grant_dc = 1'b0;
        if (state == IDLE) begin
            grant_dc = dc_req_valid && (!ic_req_valid || (streak == STREAK_MAX));
            grant_ic = ic_req_valid && !grant_dc;
        end
    end

    assign ic_req_ready = grant_ic;
    assign dc_req_ready = grant_dc;
    assign busy         = (state != IDLE);
    assign owner        = busy & lat_owner;

    always_comb begin
        state_nxt          = state;
        mem_req_valid      = 1'b0;
        mem_req_type       = READ;
        mem_req_block_addr = '0;
        mem_req_block_data = '0;
        ic_resp_valid      = 1'b0;
        dc_resp_valid      = 1'b0;
        ic_resp_block_data = '0;
        dc_resp_block_data = '0;
        case (state)
            IDLE: begin
                if (grant_ic || grant_dc) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                mem_req_valid      = 1'b1;
                mem_req_type       = lat_type;
                mem_req_block_addr = lat_addr;
                mem_req_block_data = lat_data;
                if (mem_req_ready) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (mem_resp_valid) begin
                    if (lat_owner) begin
                        dc_resp_valid      = 1'b1;
                        dc_resp_block_data = mem_resp_block_data;
                    end else begin
                        ic_resp_valid      = 1'b1;
                        ic_resp_block_data = mem_resp_block_data;
                    end
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_aL) begin
        if (!rst_aL) begin
            state     <= IDLE;
            streak    <= '0;
            lat_type  <= READ;
            lat_addr  <= '0;
            lat_data  <= '0;
            lat_owner <= 1'b0;
        end else begin
            state <= state_nxt;
            if (grant_dc) begin
                lat_type  <= dc_req_type;
                lat_addr  <= dc_req_block_addr;
                lat_data  <= dc_req_block_data;
                lat_owner <= 1'b1;
                streak    <= '0;
            end else if (grant_ic) begin
                lat_type  <= ic_req_type;
                lat_addr  <= ic_req_block_addr;
                lat_data  <= ic_req_block_data;
                lat_owner <= 1'b0;
                if (!dc_req_valid) begin
                    streak <= '0;
                end else if (streak != STREAK_MAX) begin
                    streak <= streak + 1'b1;
                end
            end
        end
    end

endmodule

`default_nettype wire
